// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment readback monitor:
// lit-segment patterns {a..g}, blank code and segment class.
package seg_pkg;

  localparam logic [6:0] LIT_0 = 7'b1111110;
  localparam logic [6:0] LIT_1 = 7'b0110000;
  localparam logic [6:0] LIT_2 = 7'b1101101;
  localparam logic [6:0] LIT_3 = 7'b1111001;
  localparam logic [6:0] LIT_4 = 7'b0110011;
  localparam logic [6:0] LIT_5 = 7'b1011011;
  localparam logic [6:0] LIT_6 = 7'b1011111;
  localparam logic [6:0] LIT_7 = 7'b1110000;
  localparam logic [6:0] LIT_8 = 7'b1111111;
  localparam logic [6:0] LIT_9 = 7'b1111011;
  localparam logic [6:0] LIT_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    SC_DIGIT,
    SC_BLANK,
    SC_INVALID
  } seg_class_e;

endpackage

// File: rtl/seg_decode.sv
// Combinational decode of an active-low segment pattern.
// Ports: seg_n (7, {a..g}) -> cls (class), bcd (4, 4'hF if not a digit).
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output seg_class_e cls,
  output logic [3:0] bcd
);

  logic [6:0] lit;

  assign lit = ~seg_n;

  always_comb begin
    cls = SC_DIGIT;
    bcd = BCD_BLANK;
    unique case (lit)
      LIT_0:     bcd = 4'd0;
      LIT_1:     bcd = 4'd1;
      LIT_2:     bcd = 4'd2;
      LIT_3:     bcd = 4'd3;
      LIT_4:     bcd = 4'd4;
      LIT_5:     bcd = 4'd5;
      LIT_6:     bcd = 4'd6;
      LIT_7:     bcd = 4'd7;
      LIT_8:     bcd = 4'd8;
      LIT_9:     bcd = 4'd9;
      LIT_BLANK: cls = SC_BLANK;
      default:   cls = SC_INVALID;
    endcase
  end

endmodule

// File: rtl/seg_bcd_capture.sv
// Passive monitor: rebuilds BCD digits from a multiplexed
// active-low 7-seg bus with per-position stability filtering.
// Ports: clk, rst (async, high), seg_n[6:0], dig_sel[N-1:0],
// err_clr -> digits_out[4N-1:0], digit_valid[N-1:0], err, update.
module seg_bcd_capture
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SAMPLE_DIV = 50,
  parameter int STABLE_CNT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    err,
  output logic                    update
);

  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam int PW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [DW-1:0]         div_q;
  logic [3:0]            cand [NUM_DIGITS];
  logic [CW-1:0]         cnt  [NUM_DIGITS];
  logic [3:0]            dig  [NUM_DIGITS];

  seg_class_e    cls;
  logic [3:0]    bcd;
  logic          tick;
  logic          hit;
  logic [PW-1:0] pos;
  logic [CW-1:0] cnt_p;
  logic [CW-1:0] nxt_cnt;
  logic          same;
  logic          commit;
  logic          err_set;

  seg_decode u_dec (
    .seg_n (seg_q),
    .cls   (cls),
    .bcd   (bcd)
  );

  assign tick = (div_q == DW'(SAMPLE_DIV - 1));
  assign hit  = tick && $onehot(sel_q);

  always_comb begin
    pos = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (sel_q[i]) pos = PW'(i);
  end

  assign cnt_p = cnt[pos];
  assign same  = (bcd == cand[pos]);

  // A valid sample always becomes the candidate, so the
  // committed value (when it happens) is simply bcd.
  always_comb begin
    nxt_cnt = CW'(1);
    if (same) begin
      if (cnt_p == CW'(STABLE_CNT)) nxt_cnt = cnt_p;
      else nxt_cnt = cnt_p + CW'(1);
    end
  end

  assign err_set = hit && (cls == SC_INVALID);
  assign commit  = hit && (cls != SC_INVALID)
                && (nxt_cnt == CW'(STABLE_CNT))
                && (bcd != dig[pos]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q       <= '1;
      sel_q       <= '0;
      div_q       <= '0;
      digit_valid <= '0;
      err         <= 1'b0;
      update      <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand[i] <= BCD_BLANK;
        cnt[i]  <= '0;
        dig[i]  <= BCD_BLANK;
      end
    end else begin
      seg_q  <= seg_n;
      sel_q  <= dig_sel;
      div_q  <= tick ? '0 : div_q + DW'(1);
      update <= commit;
      if (err_set) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      if (hit) begin
        if (cls == SC_INVALID) begin
          cnt[pos] <= '0;
        end else begin
          cand[pos] <= bcd;
          cnt[pos]  <= nxt_cnt;
        end
      end
      if (commit) begin
        dig[pos]         <= bcd;
        digit_valid[pos] <= (bcd != BCD_BLANK);
      end
    end
  end

  always_comb begin
    digits_out = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      digits_out[4*i +: 4] = dig[i];
  end

endmodule

// File: tb/tb_seg_bcd_capture.sv
// Randomized + directed bench for seg_bcd_capture against a
// sample-history reference model.
module tb_seg_bcd_capture;

  localparam int N   = 6;
  localparam int DIV = 50;
  localparam int STB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [6:0]     seg_n;
  logic [N-1:0]   dig_sel;
  logic           err_clr;
  logic [4*N-1:0] digits_out;
  logic [N-1:0]   digit_valid;
  logic           err;
  logic           update;

  always #5 clk = ~clk;

  seg_bcd_capture #(
    .NUM_DIGITS (N),
    .SAMPLE_DIV (DIV),
    .STABLE_CNT (STB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .dig_sel     (dig_sel),
    .err_clr     (err_clr),
    .digits_out  (digits_out),
    .digit_valid (digit_valid),
    .err         (err),
    .update      (update)
  );

  int checks   = 0;
  int failures = 0;

  logic [6:0] lit_tab [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011
  };

  int m_com [N];
  int hist  [N][$];
  bit m_err;
  int upd_seen;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int classify(logic [6:0] sn);
    logic [6:0] lit;
    lit = ~sn;
    for (int i = 0; i < 10; i++)
      if (lit == lit_tab[i]) return i;
    if (lit == 7'b0) return 15;
    return -1;
  endfunction

  function automatic logic [6:0] pat(int d);
    return ~lit_tab[d];
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < N; p++) begin
      m_com[p] = 15;
      hist[p].delete();
    end
    m_err = 1'b0;
  endfunction

  function automatic logic [4*N-1:0] exp_digits();
    logic [4*N-1:0] r;
    int v;
    r = '0;
    for (int p = 0; p < N; p++) begin
      v = m_com[p];
      r[4*p +: 4] = v[3:0];
    end
    return r;
  endfunction

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] r;
    for (int p = 0; p < N; p++) r[p] = (m_com[p] != 15);
    return r;
  endfunction

  // Position p commits c once its last STB valid samples
  // (since reset or its last invalid sample) all equal c.
  function automatic bit model_tick(logic [N-1:0] sel,
                                    logic [6:0] sn, bit clr);
    bit upd, set, all_eq;
    int p, c;
    upd = 0;
    set = 0;
    if ($countones(sel) == 1) begin
      p = 0;
      for (int i = 0; i < N; i++) if (sel[i]) p = i;
      c = classify(sn);
      if (c < 0) begin
        hist[p].delete();
        set = 1;
      end else begin
        hist[p].push_back(c);
        if (hist[p].size() > STB) void'(hist[p].pop_front());
        all_eq = (hist[p].size() == STB);
        foreach (hist[p][k]) if (hist[p][k] != c) all_eq = 0;
        if (all_eq && m_com[p] != c) begin
          m_com[p] = c;
          upd = 1;
        end
      end
    end
    if (set) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    return upd;
  endfunction

  // Holds one bus value for a full sample period; the last
  // edge of the period is the tick edge.
  task automatic sample(logic [N-1:0] sel, logic [6:0] sn,
                        bit clr);
    int stray;
    bit eu;
    stray = 0;
    dig_sel = sel;
    seg_n   = sn;
    for (int k = 1; k <= DIV; k++) begin
      if (k == DIV) err_clr = clr;
      @(posedge clk);
      #1;
      if (k < DIV && update) stray++;
    end
    err_clr = 1'b0;
    eu = model_tick(sel, sn, clr);
    if (update) upd_seen++;
    chk("stray_update", stray, 0);
    chk("update", update, eu);
    chk("digits", digits_out, exp_digits());
    chk("valid", digit_valid, exp_valid());
    chk("err", err, m_err);
  endtask

  task automatic check_reset_vals();
    chk("rst_digits", digits_out, 24'hFFFFFF);
    chk("rst_valid", digit_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_update", update, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [N-1:0] r_sel;
  logic [6:0]   r_seg;
  int           r;

  initial begin
    rst     = 1'b1;
    dig_sel = '0;
    seg_n   = '1;
    err_clr = 1'b0;
    upd_seen = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;

    // idle bus
    for (int t = 0; t < 20; t++)
      sample('0, 7'($urandom), 0);
    chk("idle_updates", upd_seen, 0);

    // position 2 steady "7"
    upd_seen = 0;
    for (int t = 0; t < 6; t++)
      sample(6'b000100, 7'b0001111, 0);
    chk("pos2_nibble", digits_out[11:8], 4'h7);
    chk("pos2_valid", digit_valid[2], 1);
    chk("pos2_updates", upd_seen, 1);

    // scan "123456"
    upd_seen = 0;
    for (int t = 0; t < 24; t++)
      sample(N'(1 << (t % N)), pat(t % N + 1), 0);
    chk("scan_digits", digits_out, 24'h654321);
    chk("scan_valid", digit_valid, 6'h3F);
    chk("scan_updates", upd_seen, 6);

    // alternating 3/8, then interrupted run of 3
    do_reset();
    for (int t = 0; t < 8; t++)
      sample(6'b000001, pat((t % 2) ? 8 : 3), 0);
    chk("alt_nibble", digits_out[3:0], 4'hF);
    for (int t = 0; t < 3; t++)
      sample(6'b000001, pat(3), 0);
    sample(6'b000001, 7'b0101010, 0);
    chk("inv_nibble", digits_out[3:0], 4'hF);
    chk("inv_err", err, 1);

    // err set / clear priority
    sample(6'b000010, 7'b0101010, 0);
    chk("err_set", err, 1);
    sample(6'b000010, 7'b0101010, 1);
    chk("err_set_wins", err, 1);
    sample('0, pat(0), 1);
    chk("err_cleared", err, 0);

    // reset in the middle of a filter run
    for (int t = 0; t < 4; t++)
      sample(6'b010000, pat(9), 0);
    chk("pos4_nine", digits_out[19:16], 4'h9);
    for (int t = 0; t < 2; t++)
      sample(6'b010000, pat(5), 0);
    do_reset();
    for (int t = 0; t < 3; t++)
      sample(6'b010000, pat(5), 0);
    chk("pos4_pending", digits_out[19:16], 4'hF);
    sample(6'b010000, pat(5), 0);
    chk("pos4_five", digits_out[19:16], 4'h5);

    // randomized traffic with sticky choices
    r_sel = 6'b000001;
    r_seg = pat(0);
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(99) >= 70) begin
        r = $urandom_range(99);
        if (r < 10) r_sel = '0;
        else if (r < 20) begin
          do r_sel = N'($urandom);
          while ($countones(r_sel) < 2);
        end else r_sel = N'(1 << $urandom_range(N - 1));
        r = $urandom_range(99);
        if (r < 75) r_seg = pat($urandom_range(9));
        else if (r < 85) r_seg = 7'h7F;
        else r_seg = 7'($urandom);
      end
      sample(r_sel, r_seg, $urandom_range(9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
